// File: rtl/button_scan_ctrl.sv
// button_scan_ctrl: round-robin debounce of NB buttons sharing one counter, with press and long-press events
module button_scan_ctrl #(
  parameter int NB     = 4,
  parameter int ID_W   = 2,
  parameter int N      = 100000,
  parameter int LONG_N = 50000000,
  parameter int K      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NB-1:0]   btn_in,
  input  logic            enable,
  output logic            press_valid,
  output logic [ID_W-1:0] press_id,
  output logic            long_valid,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, QUAL, PRESS, HOLD, REL} state_t;
  state_t state_q, state_d;
  logic [NB-1:0] meta_q, btn_s_q;
  logic [ID_W-1:0] sel_q, sel_d, ptr_q, ptr_d, first_id, nxt_id;
  logic [K-1:0] cnt_q, cnt_d;
  logic long_done_q, long_done_d, long_q, long_d, found, held;
  always_comb begin
    first_id = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!found && btn_s_q[(int'(ptr_q) + i) % NB]) begin
        first_id = ID_W'((int'(ptr_q) + i) % NB);
        found = 1'b1;
      end
    end
  end
  assign held = btn_s_q[sel_q];
  assign nxt_id = (sel_q == ID_W'(NB - 1)) ? '0 : sel_q + 1'b1;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    long_done_d = long_done_q;
    long_d = 1'b0;
    case (state_q)
      IDLE: if (enable && found) begin
        sel_d = first_id;
        cnt_d = '0;
        long_done_d = 1'b0;
        state_d = QUAL;
      end
      QUAL: if (!enable) state_d = IDLE;
        else if (!held) begin
          ptr_d = nxt_id;
          state_d = IDLE;
        end
        else if (cnt_q == K'(N - 1)) state_d = PRESS;
        else cnt_d = cnt_q + 1'b1;
      PRESS: begin
        cnt_d = '0;
        state_d = HOLD;
      end
      HOLD: if (!enable) state_d = IDLE;
        else if (held) begin
          cnt_d = (cnt_q == K'(LONG_N - 1)) ? cnt_q : cnt_q + 1'b1;
          long_d = (cnt_d == K'(LONG_N - 1)) && !long_done_q;
          long_done_d = long_done_q | long_d;
        end
        else begin
          cnt_d = '0;
          state_d = REL;
        end
      REL: if (!enable) state_d = IDLE;
        else if (held) begin
          cnt_d = '0;
          state_d = HOLD;
        end
        else if (cnt_q == K'(N - 1)) begin
          ptr_d = nxt_id;
          state_d = IDLE;
        end
        else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      btn_s_q <= '0;
      state_q <= IDLE;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      long_done_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      meta_q <= btn_in;
      btn_s_q <= meta_q;
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      long_done_q <= long_done_d;
      long_q <= long_d;
    end
  end
  assign press_valid = (state_q == PRESS);
  assign press_id = sel_q;
  assign long_valid = long_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_button_scan_ctrl.sv
// tb_button_scan_ctrl: directed and random stimulus against a timestamp-based reference model
module tb_button_scan_ctrl;
  localparam int N = 4;
  localparam int L = 16;
  localparam int P_IDLE = 0, P_QUAL = 1, P_PRESS = 2, P_HOLD = 3, P_REL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic enable = 1'b0;
  logic press_valid, long_valid, busy;
  logic [1:0] press_id;
  int errs = 0, checks = 0;
  int c = 0, ph = P_IDLE, m_sel = 0, m_ptr = 0, t0 = 0;
  bit done = 0, m_long = 0;
  logic [3:0] s1 = '0, s2 = '0;
  int n_press, n_long, press_at, long_at, t_start;
  int ids[$];
  button_scan_ctrl #(.NB(4), .ID_W(2), .N(N), .LONG_N(L), .K(32)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
    .press_valid(press_valid), .press_id(press_id), .long_valid(long_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // c is the index of the edge being modelled; a counter that restarted at edge t0 reads c-1-t0 just before edge c
  task automatic model_edge(input logic [3:0] b, input logic en, input logic r);
    logic [3:0] s;
    bit picked;
    s = s2;
    m_long = 0;
    if (r) begin
      ph = P_IDLE; m_sel = 0; m_ptr = 0; t0 = 0; done = 0; s1 = '0; s2 = '0;
    end else begin
      case (ph)
        P_IDLE: if (en && s != 0) begin
          picked = 0;
          for (int k = 0; k < 4; k++)
            if (!picked && s[(m_ptr + k) % 4]) begin m_sel = (m_ptr + k) % 4; picked = 1; end
          t0 = c; done = 0; ph = P_QUAL;
        end
        P_QUAL: if (!en) ph = P_IDLE;
          else if (!s[m_sel]) begin m_ptr = (m_sel + 1) % 4; ph = P_IDLE; end
          else if (c - 1 - t0 == N - 1) ph = P_PRESS;
        P_PRESS: begin t0 = c; ph = P_HOLD; end
        P_HOLD: if (!en) ph = P_IDLE;
          else if (s[m_sel]) begin
            if (!done && c - t0 >= L - 1) begin m_long = 1; done = 1; end
          end else begin t0 = c; ph = P_REL; end
        P_REL: if (!en) ph = P_IDLE;
          else if (s[m_sel]) begin t0 = c; ph = P_HOLD; end
          else if (c - 1 - t0 == N - 1) begin m_ptr = (m_sel + 1) % 4; ph = P_IDLE; end
        default: ph = P_IDLE;
      endcase
      s2 = s1; s1 = b;
    end
    c++;
  endtask
  task automatic tick(input logic [3:0] b, input logic en, input logic r);
    btn_in = b; enable = en; rst = r;
    @(posedge clk);
    model_edge(b, en, r);
    #1;
    chk("press_valid", press_valid, ph == P_PRESS);
    chk("press_id", press_id, m_sel);
    chk("long_valid", long_valid, m_long);
    chk("busy", busy, ph != P_IDLE);
    if (press_valid) begin n_press++; ids.push_back(press_id); press_at = c - 1; end
    if (long_valid) begin n_long++; long_at = c - 1; end
  endtask
  task automatic clear_ev();
    n_press = 0; n_long = 0; press_at = -1; long_at = -1; ids.delete(); t_start = c;
  endtask
  initial begin
    logic [3:0] b;
    logic en, r;
    int dur;
    clear_ev();
    for (int i = 0; i < 3; i++) tick(4'hF, 1'b1, 1'b1);
    chk("t1_rst_busy", busy, 0);
    for (int i = 0; i < 4; i++) tick(4'h0, 1'b1, 1'b0);
    chk("t1_idle_after", busy, 0);
    clear_ev();
    for (int i = 0; i < 12; i++) tick(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(4'h0, 1'b1, 1'b0);
    chk("t2_press_count", n_press, 1);
    chk("t2_press_edge", press_at - t_start, 6);
    chk("t2_press_id", ids.size() > 0 ? ids[0] : -1, 1);
    chk("t2_no_long", n_long, 0);
    clear_ev();
    for (int i = 0; i < 40; i++) tick((i % 3 < 2) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(4'h0, 1'b1, 1'b0);
    chk("t3_no_press", n_press, 0);
    tick(4'h0, 1'b1, 1'b1);
    clear_ev();
    for (int i = 0; i < 12; i++) tick(4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(4'h0, 1'b1, 1'b0);
    chk("t4_press_count", n_press, 2);
    chk("t4_first_id", ids.size() > 0 ? ids[0] : -1, 0);
    chk("t4_second_id", ids.size() > 1 ? ids[1] : -1, 2);
    clear_ev();
    for (int i = 0; i < 40; i++) tick(4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(4'h0, 1'b1, 1'b0);
    chk("t5_press_count", n_press, 1);
    chk("t5_press_id", ids.size() > 0 ? ids[0] : -1, 3);
    chk("t5_long_count", n_long, 1);
    chk("t5_long_delay", long_at - press_at, 16);
    clear_ev();
    for (int i = 0; i < 3; i++) tick(4'b0100, 1'b1, 1'b0);
    chk("t6_in_qual", busy, 1);
    tick(4'b0100, 1'b1, 1'b1);
    chk("t6_rst_busy", busy, 0);
    for (int i = 0; i < 8; i++) tick(4'h0, 1'b1, 1'b0);
    chk("t6_rst_no_press", n_press, 0);
    for (int i = 0; i < 9; i++) tick(4'b0010, 1'b1, 1'b0);
    chk("t6_in_hold", busy, 1);
    tick(4'b0010, 1'b0, 1'b0);
    chk("t6_dis_busy", busy, 0);
    for (int i = 0; i < 10; i++) tick(4'h0, 1'b1, 1'b0);
    chk("t6_one_press", n_press, 1);
    chk("t6_no_long", n_long, 0);
    for (int seg = 0; seg < 80; seg++) begin
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      dur = $urandom_range(1, 30);
      for (int i = 0; i < dur; i++) begin
        en = $urandom_range(0, 19) != 0;
        r = $urandom_range(0, 99) == 0;
        tick(b, en, r);
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
